// File: rtl/pc_pkg.sv
// pc_pkg: shared select encodings and default widths for the PC sequencer
package pc_pkg;
   typedef enum logic [1:0] {
      SEL_INC = 2'b00,
      SEL_REL = 2'b01,
      SEL_ABS = 2'b10,
      SEL_RET = 2'b11
   } sel_e;
   localparam int DEF_PC_W = 16;
   localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
// Ports: i_clk, i_rst_n (sync, active-low); i_push/i_pop/i_din request side;
// o_top (most recent entry), o_empty, o_full, o_overflow (push while full),
// o_underflow (pop while empty). Overflow overwrites the oldest entry.
module ras_stack #(
   parameter int RAS_DEPTH = 4,
   parameter int PC_W = 16
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic [PC_W-1:0] i_din,
   output logic [PC_W-1:0] o_top,
   output logic            o_empty,
   output logic            o_full,
   output logic            o_overflow,
   output logic            o_underflow
);
   localparam int PW = $clog2(RAS_DEPTH);
   logic [PC_W-1:0] r_mem [RAS_DEPTH];
   logic [PW-1:0]   r_ptr;
   logic [PW:0]     r_cnt;
   logic [PW-1:0]   w_ptr_up;
   assign w_ptr_up    = r_ptr + 1'b1;
   assign o_top       = r_mem[r_ptr];
   assign o_empty     = r_cnt == '0;
   assign o_full      = r_cnt == (PW+1)'(RAS_DEPTH);
   assign o_overflow  = i_push & o_full;
   assign o_underflow = i_pop & o_empty;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr <= '0;
         r_cnt <= '0;
      end else if (i_push) begin
         // the pointer wraps, so a push when full lands on the oldest slot
         r_ptr <= w_ptr_up;
         r_cnt <= o_full ? r_cnt : r_cnt + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_ptr <= r_ptr - 1'b1;
         r_cnt <= r_cnt - 1'b1;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_push) r_mem[w_ptr_up] <= i_din;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with branch/jump/return and RAS.
// Ports: i_clk, i_rst_n (sync, active-low), i_stall holds all state,
// i_select (00 inc, 01 rel, 10 abs, 11 ret), i_call pushes pc+INC on 01/10,
// i_target offset/address; o_pc, o_ras_empty, o_ras_full, o_ras_err (sticky),
// o_trap (one-cycle misalignment pulse).
// Optional macro PC_MISALIGN_TRAP_EN enables redirect alignment trapping to
// TRAP_VEC; without it o_trap stays 0.
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int PC_W = DEF_PC_W,
   parameter int INC = 1,
   parameter logic [PC_W-1:0] RESET_VEC = PC_W'(DEF_RESET_VEC),
   parameter int RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] TRAP_VEC = PC_W'(16'hFFF0)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_stall,
   input  logic [1:0]      i_select,
   input  logic            i_call,
   input  logic [PC_W-1:0] i_target,
   output logic [PC_W-1:0] o_pc,
   output logic            o_ras_empty,
   output logic            o_ras_full,
   output logic            o_ras_err,
   output logic            o_trap
);
   logic [PC_W-1:0] r_pc;
   logic            r_err;
   logic            r_trap;
   logic [PC_W-1:0] w_inc;
   logic [PC_W-1:0] w_next;
   logic [PC_W-1:0] w_top;
   logic            w_push;
   logic            w_pop;
   logic            w_ovf;
   logic            w_unf;
   logic            w_trap;
   assign w_inc  = r_pc + PC_W'(INC);
   assign w_push = !i_stall && i_call && (i_select == SEL_REL || i_select == SEL_ABS);
   assign w_pop  = !i_stall && i_select == SEL_RET;
   always_comb begin
      w_next = i_select == SEL_REL ? r_pc + i_target :
               i_select == SEL_ABS ? i_target :
               i_select == SEL_RET ? (o_ras_empty ? w_inc : w_top) : w_inc;
   end
`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INC - 1);
   assign w_trap = !i_stall && i_select != SEL_INC && |(w_next & ALIGN_MASK);
`else
   assign w_trap = 1'b0;
`endif
   ras_stack #(.RAS_DEPTH(RAS_DEPTH), .PC_W(PC_W)) u_ras (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_pop       (w_pop),
      .i_din       (w_inc),
      .o_top       (w_top),
      .o_empty     (o_ras_empty),
      .o_full      (o_ras_full),
      .o_overflow  (w_ovf),
      .o_underflow (w_unf)
   );
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc   <= RESET_VEC;
         r_err  <= 1'b0;
         r_trap <= 1'b0;
      end else begin
         r_pc   <= i_stall ? r_pc : (w_trap ? TRAP_VEC : w_next);
         r_err  <= r_err | w_ovf | w_unf;
         r_trap <= w_trap;
      end
   end
   assign o_pc      = r_pc;
   assign o_ras_err = r_err;
   assign o_trap    = r_trap;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic [1:0]  sel = 2'b00;
   logic        call = 1'b0;
   logic [15:0] tgt = '0;
   logic [15:0] pc;
   logic        empty, full, err, trap;
   logic [1:0]  sel2 = 2'b00;
   logic [15:0] tgt2 = '0;
   logic [15:0] pc2;
   logic        empty2, full2, err2, trap2;
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_select(sel), .i_call(call),
      .i_target(tgt), .o_pc(pc), .o_ras_empty(empty), .o_ras_full(full),
      .o_ras_err(err), .o_trap(trap)
   );

   pc_sequencer #(.INC(2)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_stall(1'b0), .i_select(sel2), .i_call(1'b0),
      .i_target(tgt2), .o_pc(pc2), .o_ras_empty(empty2), .o_ras_full(full2),
      .o_ras_err(err2), .o_trap(trap2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] s, input logic c, input logic [15:0] t);
      sel = s;
      call = c;
      tgt = t;
      @(posedge clk);
      #1;
   endtask

   initial begin
      step(2'b00, 0, 16'h0);
      check("rst_pc", pc, 16'h0000);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_err", err, 0);
      check("rst_trap", trap, 0);
      rst_n = 1'b1;
      step(2'b00, 0, 16'h0); check("inc1", pc, 16'h0001);
      step(2'b00, 0, 16'h0); check("inc2", pc, 16'h0002);
      step(2'b00, 1, 16'h0); check("inc3_call_ignored", pc, 16'h0003);
      check("inc_empty", empty, 1);
      check("inc_err", err, 0);
      step(2'b10, 0, 16'h0080); check("jmp80", pc, 16'h0080);
      step(2'b01, 0, 16'hFFF8); check("rel_neg", pc, 16'h0078);
      step(2'b10, 0, 16'hFFFF); check("jmpFFFF", pc, 16'hFFFF);
      step(2'b00, 0, 16'h0);    check("inc_wrap", pc, 16'h0000);
      step(2'b10, 0, 16'h0080);
      step(2'b10, 1, 16'h8808); check("call_pc", pc, 16'h8808);
      check("call_empty", empty, 0);
      step(2'b11, 0, 16'h0);    check("ret_pc", pc, 16'h0081);
      check("ret_empty", empty, 1);
      check("ret_err", err, 0);
      step(2'b10, 1, 16'h1000);
      step(2'b10, 1, 16'h2000);
      step(2'b10, 1, 16'h3000);
      step(2'b10, 1, 16'h4000);
      check("four_full", full, 1);
      check("four_err", err, 0);
      step(2'b10, 1, 16'h5000); check("ovf_pc", pc, 16'h5000);
      check("ovf_full", full, 1);
      check("ovf_err", err, 1);
      step(2'b11, 0, 16'h0); check("pop1", pc, 16'h4001);
      check("pop1_full", full, 0);
      step(2'b11, 0, 16'h0); check("pop2", pc, 16'h3001);
      step(2'b11, 0, 16'h0); check("pop3", pc, 16'h2001);
      step(2'b11, 0, 16'h0); check("pop4", pc, 16'h1001);
      check("pop4_empty", empty, 1);
      step(2'b11, 0, 16'h0); check("unf_pc", pc, 16'h1002);
      check("unf_empty", empty, 1);
      check("unf_err", err, 1);
      step(2'b10, 1, 16'h6000); check("call6", pc, 16'h6000);
      stall = 1'b1;
      step(2'b10, 1, 16'h7777); check("stall_pc", pc, 16'h6000);
      check("stall_empty", empty, 0);
      check("stall_full", full, 0);
      stall = 1'b0;
      step(2'b11, 0, 16'h0); check("ret_after_stall", pc, 16'h1003);
      check("ret_after_stall_empty", empty, 1);
      step(2'b10, 1, 16'h7000);
      rst_n = 1'b0;
      step(2'b11, 0, 16'h0); check("midrst_pc", pc, 16'h0000);
      check("midrst_empty", empty, 1);
      check("midrst_err", err, 0);
      rst_n = 1'b1;
      step(2'b11, 0, 16'h0); check("unf_after_rst_pc", pc, 16'h0001);
      check("unf_after_rst_err", err, 1);
      rst_n = 1'b0;
      step(2'b00, 0, 16'h0);
      check("inc2_rst_pc", pc2, 16'h0000);
      rst_n = 1'b1;
      sel2 = 2'b10;
      tgt2 = 16'h0003;
      @(posedge clk);
      #1;
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_pc", pc2, 16'hFFF0);
      check("mis_trap", trap2, 1);
`else
      check("mis_pc", pc2, 16'h0003);
      check("mis_trap", trap2, 0);
`endif
      sel2 = 2'b00;
      @(posedge clk);
      #1;
      check("mis_trap_clear", trap2, 0);
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_next_pc", pc2, 16'hFFF2);
`else
      check("mis_next_pc", pc2, 16'h0005);
`endif
      sel2 = 2'b10;
      tgt2 = 16'h0040;
      @(posedge clk);
      #1;
      check("aligned_pc", pc2, 16'h0040);
      check("aligned_trap", trap2, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit; replaces the combinational PC adjust stage.
- Owns the registered PC and computes each next PC from increment, relative branch, absolute jump or return.
- Includes a return-address stack (RAS) for call/return.
- Sits between the control unit, which drives select, call and target, and instruction fetch, which consumes pc.

Parameters:
- PC_W, 16, PC and target width in bits.
- INC, 1, sequential increment added to pc.
- RESET_VEC, 0, pc value loaded on reset.
- RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.
- TRAP_VEC, 16'hFFF0, redirect target for misalignment traps (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold pc and RAS this cycle.
- select  in  2  00 increment, 01 relative branch, 10 absolute jump, 11 return.
- call  in  1  with select 01 or 10, push return address (pc+INC).
- target  in  PC_W  two's-complement offset (select 01) or absolute address (select 10).
- pc  out  PC_W  current program counter (registered).
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_err  out  1  sticky flag: RAS overflow or underflow occurred.
- trap  out  1  one-cycle pulse on misalignment (optional feature only; otherwise tied 0).

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous and active-low: rst_n=0 at an edge loads pc=RESET_VEC, RAS count=0, ras_err=0, trap=0. Consequently ras_empty=1 and ras_full=0. Reset overrides stall and every other input, including mid-call or mid-return.
- Latency: a decision presented in cycle N is visible on pc after edge N.
- stall=1: pc, RAS contents, RAS pointer and ras_err hold; no push or pop; trap=0.
- select 00: pc <= pc+INC.
- select 01: pc <= pc+target, with target treated as signed.
- select 10: pc <= target.
- select 11:
  - RAS non-empty: pc <= top entry; count decrements.
  - RAS empty (underflow): pc <= pc+INC; ras_err <= 1; count stays 0.
- Arithmetic: all sums are modulo 2^PC_W and wrap silently. Example with PC_W=16: 16'hFFFF+1 = 16'h0000.
- call=1 with select 01 or 10: push pc+INC (wrapped value) in the same edge as the redirect.
- call=1 with select 00 or 11: call is ignored; no push.
- Push when ras_full (overflow): the RAS is circular. The oldest entry is overwritten, count stays RAS_DEPTH, and ras_err <= 1.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH). Both are derived from registered count, so they are valid in the cycle after the edge.
- ras_err clears only on reset.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined: on a non-stalled select 01/10/11 whose computed next pc is not a multiple of INC (INC a power of two), pc <= TRAP_VEC and trap pulses 1 for one cycle.
  - A push requested with the same redirect still occurs.
  - A pop still decrements.
- Undefined: no alignment check; trap is constant 0; TRAP_VEC is unused.

Decomposition:
- Shared package pc_pkg: select encodings (SEL_INC=2'b00, SEL_REL=2'b01, SEL_ABS=2'b10, SEL_RET=2'b11), default PC_W, default RESET_VEC.
- One sub-module: ras_stack (parameters RAS_DEPTH, PC_W).
  - Inputs: push, pop, din.
  - Outputs: top, empty, full, overflow, underflow.
  - Circular top pointer plus count.
- pc_sequencer holds the pc register, next-pc mux and ras_err.

Test Plan:
- Reset/increment: rst_n=0 then 1, select=00 for 3 edges -> pc 0000, 0001, 0002, 0003; ras_empty=1, ras_err=0.
- Relative/wrap: pc=16'h0080, select=01, target=16'hFFF8 -> pc=16'h0078. Then pc=16'hFFFF, select=00 -> pc=16'h0000.
- Call/return: pc=16'h0080, select=10, call=1, target=16'h8808 -> pc=16'h8808. Then select=11 -> pc=16'h0081, ras_empty=1.
- Overflow/underflow: 5 call-jumps with RAS_DEPTH=4 -> ras_full=1, ras_err=1; 4 returns yield the last 4 pushed addresses in LIFO order. A 5th return -> pc+1 and ras_empty stays 1.
- Stall and reset mid-operation: stall=1 with select=10, call=1 -> pc and count unchanged. Then rst_n=0 with select=11 -> pc=RESET_VEC, count=0, ras_err=0.
- With PC_MISALIGN_TRAP_EN, INC=2: select=10, target=16'h0003 -> pc=TRAP_VEC and trap=1 for one cycle. Without the macro -> pc=16'h0003, trap=0.
